triangle_assembler: RTL and testbench
=====================================

# triangle_assembler

Collects post-processed vertices from the vertex post-processor into triangles, one triangle per three accepted vertices. It computes the signed doubled area and a screen-clamped bounding box, culls triangles that are invalid, degenerate, off-screen or back-facing, and hands the surviving triangles to the rasterizer over a valid/ready handshake. It sits between the vertex post-processor and the rasterizer.

## Interface
- DATAWIDTH, 12, signed width of pixel x/y and depth z; matches post-processor output width
- WIDTH, 320, screen width in pixels
- HEIGHT, 320, screen height in pixels
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- ready  out  1  high when a vertex can be accepted; combinational from state
- i_vertex[3]  in  3×DATAWIDTH signed  {x, y, z} in pixel space
- i_vertex_dv  in  1  vertex strobe; taken when high together with ready
- i_vertex_invalid  in  1  vertex was clipped; sampled with i_vertex_dv
- i_flush  in  1  discard any partially collected triangle
- o_tri[3][3]  out  9×DATAWIDTH signed  vertices v0..v2 as {x, y, z}
- o_area  out  2·DATAWIDTH+2 signed  doubled signed area
- o_bb_min_x, o_bb_max_x, o_bb_min_y, o_bb_max_y  out  DATAWIDTH signed each  clamped bounding box
- o_valid  out  1  triangle available for the rasterizer
- i_ready  in  1  rasterizer accepts; a transfer occurs when o_valid && i_ready
- o_culled  out  1  one-cycle pulse per dropped triangle

## Operation
- States: TA_COLLECT, TA_AREA, TA_BBOX, TA_OUTPUT.
- TA_COLLECT
  - ready=1.
  - Each accepted vertex is stored in slot vcnt (0..2), vcnt increments, and i_vertex_invalid is ORed into a sticky tri_invalid flag.
  - Accepting the vertex with vcnt==2 moves the block to TA_AREA, with vcnt wrapping to 0.
- TA_AREA
  - Registers area = (x1−x0)·(y2−y0) − (x2−x0)·(y1−y0).
  - Operands are sign-extended to full width, so the result never overflows.
- TA_BBOX
  - Registers the min/max of x and y over the three vertices, clamped to x∈[0,WIDTH−1] and y∈[0,HEIGHT−1].
  - Evaluates cull = tri_invalid | (area==0) | offscreen | backface term (see Configuration).
  - offscreen = unclamped max_x<0 | min_x>WIDTH−1 | max_y<0 | min_y>HEIGHT−1.
  - If cull: o_culled pulses, tri_invalid clears, next state is TA_COLLECT.
  - Otherwise: next state is TA_OUTPUT.
- TA_OUTPUT
  - o_valid=1; all outputs are held stable.
  - On o_valid && i_ready: tri_invalid clears, next state is TA_COLLECT.
- i_flush
  - Has priority in every state: vcnt←0, tri_invalid←0, state←TA_COLLECT, o_valid←0.
  - A vertex presented in the same cycle is dropped.
  - A triangle flushed in TA_OUTPUT is not transferred and does not pulse o_culled.
- ready is 0 in TA_AREA, TA_BBOX and TA_OUTPUT. The upstream post-processor holds done/data only for one cycle, so its controller must not present vertices while ready is 0. The vertex strobe is ignored when ready=0.

## Timing
- Reset values: all outputs 0 (o_tri, o_area, o_bb_*, o_valid, o_culled), vcnt=0, tri_invalid=0, state TA_COLLECT.
  - ready is 1 in the first cycle after reset release.
- Latency: third vertex accepted at edge T → TA_AREA in cycle T+1 → TA_BBOX in T+2 → o_valid high in T+3.
  - A culled triangle pulses o_culled in cycle T+2 and ready is 1 again in T+3.
- Back-to-back throughput: with i_ready held 1, a new triangle's first vertex can be accepted in cycle T+4.
- o_valid stays high until the handshake completes; the outputs must not change while o_valid=1.
- Reset mid-operation: everything returns to reset values on the next edge; partial triangles are lost.

## Configuration
- BACKFACE_CULL_EN
  - Defined: a triangle with area<0 is culled. Front-facing means positive area with screen y pointing down.
  - Undefined: both windings pass. The rasterizer receives negative o_area and must handle the edge-function sign itself.
- Degenerate triangles (area==0) are culled in both cases.

## Test plan
- Front-facing triangle: vertices (10,10,5), (50,10,5), (10,50,5).
  - Required: o_area=1600, bbox x 10..50 and y 10..50, o_valid at T+3.
  - Holding i_ready=0 for 5 cycles keeps all outputs stable.
- Back-facing triangle: vertices (10,10), (10,50), (50,10).
  - With BACKFACE_CULL_EN: o_culled pulse, no o_valid.
  - Without it: o_valid with o_area=−1600.
- Clamping: vertices (−20,5), (100,5), (40,400).
  - Required: bbox min_x=0, max_x=100, min_y=5, max_y=319.
  - Off-screen case: vertices (400,10), (450,10), (400,60) → culled.
- Invalid vertex: the second vertex carries i_vertex_invalid=1.
  - Required: that triangle is culled.
  - The next triangle (20,20), (60,20), (20,60) is emitted normally, showing tri_invalid was cleared.
- Flush: present 2 vertices, then assert i_flush together with a third vertex.
  - Required: no output, vcnt=0.
  - The next 3 vertices form one complete triangle.
  - Asserting i_flush in TA_OUTPUT drops o_valid the next cycle with no transfer.

Source files
------------

// File: rtl/triangle_assembler_if.sv
// =============================================================================
// Module   : triangle_assembler_if
// Brief    : Vertex-in / triangle-out bus of the triangle assembler.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

interface triangle_assembler_if #(
  parameter int DATAWIDTH = 12
);
  // Vertex side (from the vertex post-processor)
  logic                          ready;
  logic signed [DATAWIDTH-1:0]   i_vertex [3];
  logic                          i_vertex_dv;
  logic                          i_vertex_invalid;
  logic                          i_flush;

  // Triangle side (to the rasterizer)
  logic signed [DATAWIDTH-1:0]   o_tri [3][3];
  logic signed [2*DATAWIDTH+1:0] o_area;
  logic signed [DATAWIDTH-1:0]   o_bb_min_x;
  logic signed [DATAWIDTH-1:0]   o_bb_max_x;
  logic signed [DATAWIDTH-1:0]   o_bb_min_y;
  logic signed [DATAWIDTH-1:0]   o_bb_max_y;
  logic                          o_valid;
  logic                          i_ready;
  logic                          o_culled;

  modport master (
    input  ready,
    output i_vertex, i_vertex_dv, i_vertex_invalid, i_flush,
    input  o_tri, o_area, o_bb_min_x, o_bb_max_x, o_bb_min_y, o_bb_max_y,
    input  o_valid, o_culled,
    output i_ready
  );

  modport slave (
    output ready,
    input  i_vertex, i_vertex_dv, i_vertex_invalid, i_flush,
    output o_tri, o_area, o_bb_min_x, o_bb_max_x, o_bb_min_y, o_bb_max_y,
    output o_valid, o_culled,
    input  i_ready
  );
endinterface

`default_nettype wire

// File: rtl/triangle_assembler.sv
// =============================================================================
// Module   : triangle_assembler
// Brief    : Groups vertices into triangles, computes doubled area and clamped
//            bounding box, culls and forwards survivors to the rasterizer.
// Options  : BACKFACE_CULL_EN - when defined, negative-area triangles are culled.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module triangle_assembler #(
  parameter int DATAWIDTH = 12,
  parameter int WIDTH     = 320,
  parameter int HEIGHT    = 320
) (
  input wire              clk,
  input wire              rstn,
  triangle_assembler_if.slave bus
);

  localparam int AW = 2*DATAWIDTH + 2;
  localparam logic signed [DATAWIDTH-1:0] c_x_max = DATAWIDTH'(WIDTH - 1);
  localparam logic signed [DATAWIDTH-1:0] c_y_max = DATAWIDTH'(HEIGHT - 1);

  typedef enum logic [1:0] {
    TA_COLLECT = 2'd0,
    TA_AREA    = 2'd1,
    TA_BBOX    = 2'd2,
    TA_OUTPUT  = 2'd3
  } ta_state_t;

  ta_state_t                    r_state;
  logic [1:0]                   r_vcnt;
  logic                         r_tri_invalid;
  logic signed [DATAWIDTH-1:0]  r_vtx [3][3];
  logic signed [DATAWIDTH-1:0]  r_tri [3][3];
  logic signed [AW-1:0]         r_area;
  logic signed [DATAWIDTH-1:0]  r_bb_min_x, r_bb_max_x, r_bb_min_y, r_bb_max_y;
  logic                         r_valid;
  logic                         r_culled;

  function automatic logic signed [AW-1:0] sx(input logic signed [DATAWIDTH-1:0] v);
    return {{(AW-DATAWIDTH){v[DATAWIDTH-1]}}, v};
  endfunction

  function automatic logic signed [DATAWIDTH-1:0] min3(
    input logic signed [DATAWIDTH-1:0] a,
    input logic signed [DATAWIDTH-1:0] b,
    input logic signed [DATAWIDTH-1:0] c
  );
    logic signed [DATAWIDTH-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic signed [DATAWIDTH-1:0] max3(
    input logic signed [DATAWIDTH-1:0] a,
    input logic signed [DATAWIDTH-1:0] b,
    input logic signed [DATAWIDTH-1:0] c
  );
    logic signed [DATAWIDTH-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic signed [DATAWIDTH-1:0] clamp(
    input logic signed [DATAWIDTH-1:0] v,
    input logic signed [DATAWIDTH-1:0] hi
  );
    if (v[DATAWIDTH-1]) return '0;
    if (v > hi)         return hi;
    return v;
  endfunction

  // Doubled signed area on full-width operands; cannot overflow AW bits.
  logic signed [AW-1:0] w_dx1, w_dy1, w_dx2, w_dy2, w_area;
  assign w_dx1  = sx(r_vtx[1][0]) - sx(r_vtx[0][0]);
  assign w_dy1  = sx(r_vtx[1][1]) - sx(r_vtx[0][1]);
  assign w_dx2  = sx(r_vtx[2][0]) - sx(r_vtx[0][0]);
  assign w_dy2  = sx(r_vtx[2][1]) - sx(r_vtx[0][1]);
  assign w_area = (w_dx1 * w_dy2) - (w_dx2 * w_dy1);

  logic signed [DATAWIDTH-1:0] w_min_x, w_max_x, w_min_y, w_max_y;
  assign w_min_x = min3(r_vtx[0][0], r_vtx[1][0], r_vtx[2][0]);
  assign w_max_x = max3(r_vtx[0][0], r_vtx[1][0], r_vtx[2][0]);
  assign w_min_y = min3(r_vtx[0][1], r_vtx[1][1], r_vtx[2][1]);
  assign w_max_y = max3(r_vtx[0][1], r_vtx[1][1], r_vtx[2][1]);

  logic w_offscreen;
  assign w_offscreen = w_max_x[DATAWIDTH-1] | (w_min_x > c_x_max) |
                       w_max_y[DATAWIDTH-1] | (w_min_y > c_y_max);

  logic w_backface;
`ifdef BACKFACE_CULL_EN
  assign w_backface = w_area[AW-1];
`else
  assign w_backface = 1'b0;
`endif

  logic w_cull;
  assign w_cull = r_tri_invalid | (w_area == '0) | w_offscreen | w_backface;

  // The cull decision only depends on the stored vertices, so it is latched while
  // leaving TA_AREA; that makes o_culled a registered pulse during TA_BBOX.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= TA_COLLECT;
      r_vcnt        <= 2'd0;
      r_tri_invalid <= 1'b0;
      r_area        <= '0;
      r_bb_min_x    <= '0;
      r_bb_max_x    <= '0;
      r_bb_min_y    <= '0;
      r_bb_max_y    <= '0;
      r_valid       <= 1'b0;
      r_culled      <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_vtx[i][j] <= '0;
          r_tri[i][j] <= '0;
        end
      end
    end else begin
      r_culled <= 1'b0;
      if (bus.i_flush) begin
        r_vcnt        <= 2'd0;
        r_tri_invalid <= 1'b0;
        r_valid       <= 1'b0;
        r_state       <= TA_COLLECT;
      end else begin
        case (r_state)
          TA_COLLECT: begin
            if (bus.i_vertex_dv) begin
              for (int i = 0; i < 3; i++) begin
                if (r_vcnt == 2'(i)) r_vtx[i] <= bus.i_vertex;
              end
              r_tri_invalid <= r_tri_invalid | bus.i_vertex_invalid;
              if (r_vcnt == 2'd2) begin
                r_vcnt  <= 2'd0;
                r_state <= TA_AREA;
              end else begin
                r_vcnt  <= r_vcnt + 2'd1;
              end
            end
          end
          TA_AREA: begin
            r_area   <= w_area;
            r_tri    <= r_vtx;
            r_culled <= w_cull;
            r_state  <= TA_BBOX;
          end
          TA_BBOX: begin
            r_bb_min_x <= clamp(w_min_x, c_x_max);
            r_bb_max_x <= clamp(w_max_x, c_x_max);
            r_bb_min_y <= clamp(w_min_y, c_y_max);
            r_bb_max_y <= clamp(w_max_y, c_y_max);
            if (r_culled) begin
              r_tri_invalid <= 1'b0;
              r_state       <= TA_COLLECT;
            end else begin
              r_valid <= 1'b1;
              r_state <= TA_OUTPUT;
            end
          end
          TA_OUTPUT: begin
            if (bus.i_ready) begin
              r_valid       <= 1'b0;
              r_tri_invalid <= 1'b0;
              r_state       <= TA_COLLECT;
            end
          end
          default: r_state <= TA_COLLECT;
        endcase
      end
    end
  end

  assign bus.ready      = (r_state == TA_COLLECT);
  assign bus.o_area     = r_area;
  assign bus.o_bb_min_x = r_bb_min_x;
  assign bus.o_bb_max_x = r_bb_max_x;
  assign bus.o_bb_min_y = r_bb_min_y;
  assign bus.o_bb_max_y = r_bb_max_y;
  assign bus.o_valid    = r_valid;
  assign bus.o_culled   = r_culled;

  for (genvar gi = 0; gi < 3; gi++) begin : g_tri_v
    for (genvar gj = 0; gj < 3; gj++) begin : g_tri_c
      assign bus.o_tri[gi][gj] = r_tri[gi][gj];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_triangle_assembler.sv
// =============================================================================
// Module   : tb_triangle_assembler
// Brief    : Directed self-checking bench for triangle_assembler.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_triangle_assembler;

  localparam int DW = 12;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  triangle_assembler_if #(.DATAWIDTH(DW)) bus ();

  triangle_assembler #(
    .DATAWIDTH (DW),
    .WIDTH     (320),
    .HEIGHT    (320)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vtx(input int x, input int y, input int z);
    bus.i_vertex[0] = DW'(x);
    bus.i_vertex[1] = DW'(y);
    bus.i_vertex[2] = DW'(z);
  endtask

  task automatic send_vtx(input int x, input int y, input int z, input bit inv);
    set_vtx(x, y, z);
    bus.i_vertex_dv      = 1'b1;
    bus.i_vertex_invalid = inv;
    tick();
    bus.i_vertex_dv      = 1'b0;
    bus.i_vertex_invalid = 1'b0;
  endtask

  // Sends three vertices and checks the cycle-exact T+1..T+3 response.
  task automatic send_tri(input string tag,
                          input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input bit inv1, input bit exp_cull);
    send_vtx(x0, y0, 5, 1'b0);
    send_vtx(x1, y1, 5, inv1);
    send_vtx(x2, y2, 5, 1'b0);
    check({tag, "_ready_t1"}, longint'(bus.ready), 0);
    tick();
    check({tag, "_culled_t2"}, longint'(bus.o_culled), longint'(exp_cull));
    check({tag, "_valid_t2"}, longint'(bus.o_valid), 0);
    tick();
    check({tag, "_valid_t3"}, longint'(bus.o_valid), longint'(!exp_cull));
    check({tag, "_ready_t3"}, longint'(bus.ready), longint'(exp_cull));
    check({tag, "_culled_t3"}, longint'(bus.o_culled), 0);
  endtask

  task automatic check_geom(input string tag, input longint area,
                            input longint mnx, input longint mxx,
                            input longint mny, input longint mxy);
    check({tag, "_area"},  longint'(bus.o_area),     area);
    check({tag, "_min_x"}, longint'(bus.o_bb_min_x), mnx);
    check({tag, "_max_x"}, longint'(bus.o_bb_max_x), mxx);
    check({tag, "_min_y"}, longint'(bus.o_bb_min_y), mny);
    check({tag, "_max_y"}, longint'(bus.o_bb_max_y), mxy);
  endtask

  task automatic handshake(input string tag);
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    check({tag, "_valid_after_xfer"}, longint'(bus.o_valid), 0);
    check({tag, "_ready_after_xfer"}, longint'(bus.ready), 1);
  endtask

  initial begin
    set_vtx(0, 0, 0);
    bus.i_vertex_dv      = 1'b0;
    bus.i_vertex_invalid = 1'b0;
    bus.i_flush          = 1'b0;
    bus.i_ready          = 1'b0;
    rstn                 = 1'b0;
    repeat (3) tick();

    check("rst_valid",  longint'(bus.o_valid),     0);
    check("rst_culled", longint'(bus.o_culled),    0);
    check("rst_area",   longint'(bus.o_area),      0);
    check("rst_min_x",  longint'(bus.o_bb_min_x),  0);
    check("rst_max_y",  longint'(bus.o_bb_max_y),  0);
    check("rst_tri22",  longint'(bus.o_tri[2][2]), 0);
    rstn = 1'b1;
    check("rst_ready_first", longint'(bus.ready), 1);

    // Front-facing triangle, held under backpressure
    send_tri("front", 10, 10, 50, 10, 10, 50, 1'b0, 1'b0);
    check_geom("front", 1600, 10, 50, 10, 50);
    check("front_v1x", longint'(bus.o_tri[1][0]), 50);
    check("front_v2y", longint'(bus.o_tri[2][1]), 50);
    check("front_v0z", longint'(bus.o_tri[0][2]), 5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", longint'(bus.o_valid),     1);
      check("hold_area",  longint'(bus.o_area),      1600);
      check("hold_max_x", longint'(bus.o_bb_max_x),  50);
      check("hold_v1x",   longint'(bus.o_tri[1][0]), 50);
      check("hold_ready", longint'(bus.ready),       0);
    end
    handshake("front");

    // Back-facing triangle
`ifdef BACKFACE_CULL_EN
    send_tri("back", 10, 10, 10, 50, 50, 10, 1'b0, 1'b1);
`else
    send_tri("back", 10, 10, 10, 50, 50, 10, 1'b0, 1'b0);
    check_geom("back", -1600, 10, 50, 10, 50);
    handshake("back");
`endif

    // Clamping and off-screen
    send_tri("clamp", -20, 5, 100, 5, 40, 400, 1'b0, 1'b0);
    check_geom("clamp", 47400, 0, 100, 5, 319);
    handshake("clamp");
    send_tri("offscr", 400, 10, 450, 10, 400, 60, 1'b0, 1'b1);

    // Degenerate (collinear)
    send_tri("degen", 0, 0, 10, 10, 20, 20, 1'b0, 1'b1);

    // Invalid vertex, then a clean triangle
    send_tri("inval", 20, 20, 60, 20, 20, 60, 1'b1, 1'b1);
    send_tri("after_inval", 20, 20, 60, 20, 20, 60, 1'b0, 1'b0);
    check_geom("after_inval", 1600, 20, 60, 20, 60);
    handshake("after_inval");

    // Flush with the third vertex
    send_vtx(1, 1, 0, 1'b0);
    send_vtx(90, 1, 0, 1'b0);
    set_vtx(1, 90, 0);
    bus.i_vertex_dv = 1'b1;
    bus.i_flush     = 1'b1;
    tick();
    bus.i_vertex_dv = 1'b0;
    bus.i_flush     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("flush_no_valid",  longint'(bus.o_valid),  0);
      check("flush_no_culled", longint'(bus.o_culled), 0);
      check("flush_ready",     longint'(bus.ready),    1);
      tick();
    end
    send_tri("post_flush", 30, 30, 70, 30, 30, 70, 1'b0, 1'b0);
    check_geom("post_flush", 1600, 30, 70, 30, 70);

    // Flush while presenting a triangle
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    check("oflush_valid",  longint'(bus.o_valid),  0);
    check("oflush_culled", longint'(bus.o_culled), 0);
    check("oflush_ready",  longint'(bus.ready),    1);
    tick();
    check("oflush_valid2", longint'(bus.o_valid),  0);

    // Back-to-back: next first vertex accepted in T+4
    send_tri("b2b_a", 0, 0, 8, 0, 0, 8, 1'b0, 1'b0);
    check_geom("b2b_a", 64, 0, 8, 0, 8);
    handshake("b2b_a");
    send_tri("b2b_b", 100, 200, 100, 150, 160, 200, 1'b0, 1'b0);
    check_geom("b2b_b", 3000, 100, 160, 150, 200);
    handshake("b2b_b");

    // Reset mid-collection
    send_vtx(5, 5, 0, 1'b0);
    send_vtx(9, 5, 0, 1'b0);
    rstn = 1'b0;
    tick();
    check("mrst_area",  longint'(bus.o_area),  0);
    check("mrst_valid", longint'(bus.o_valid), 0);
    check("mrst_ready", longint'(bus.ready),   1);
    rstn = 1'b1;
    send_tri("post_rst", 10, 10, 50, 10, 10, 50, 1'b0, 1'b0);
    check_geom("post_rst", 1600, 10, 50, 10, 50);
    handshake("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
